multicore_run_controller: RTL

//  Parametrised run sequencer for an N-core processor array sharing IROM/data memory.

---
 rtl/multicore_run_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multicore_run_controller.sv
// rtl/multicore_run_controller.sv - run sequencer for an N-core array: IDLE/LOAD/RUN/DONE with mask completion and watchdog
module multicore_run_controller #(
   parameter int NUM_CORES   = 4,
   parameter int CNT_W       = 16,
   parameter int LOAD_CYCLES = 8,
   parameter int TIMEOUT     = 0
) (
   input  logic                 clock,
   input  logic                 rst_r,
   input  logic                 start_process,
   input  logic                 abort,
   input  logic [NUM_CORES-1:0] core_mask,
   input  logic [NUM_CORES-1:0] end_process,
   output logic [NUM_CORES-1:0] core_run,
   output logic [1:0]           status,
   output logic                 g1,
   output logic                 g2,
   output logic                 g3,
   output logic [NUM_CORES-1:0] done_mask,
   output logic [CNT_W-1:0]     cycle_count,
   output logic                 timed_out
);

   localparam int LOAD_N = (LOAD_CYCLES < 1) ? 1 : LOAD_CYCLES;
   localparam int LOAD_W = (LOAD_N > 1) ? $clog2(LOAD_N) : 1;
   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_N - 1);
   localparam bit WDOG_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_EN ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_start_q;
   logic [NUM_CORES-1:0]  r_mask;
   logic [LOAD_W-1:0]     r_load_cnt;
   logic [NUM_CORES-1:0]  r_core_run;
   logic [NUM_CORES-1:0]  r_done_mask;
   logic [CNT_W-1:0]      r_cycle_count;
   logic                  r_timed_out;

   logic                  w_rise;
   logic                  w_start_ok;
   logic                  w_idle_like;
   logic [NUM_CORES-1:0]  w_done_next;
   logic                  w_finish;
   logic                  w_load_end;
   logic                  w_timeout;
   logic                  w_cnt_sat;

   // A start that coincides with abort is dropped, as is one with an empty mask
   assign w_rise      = start_process & ~r_start_q;
   assign w_start_ok  = w_rise & ~abort & (|core_mask);
   assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_done_next = r_done_mask | (end_process & r_mask);
   assign w_finish    = (w_done_next == r_mask);
   assign w_load_end  = (r_load_cnt == LOAD_LAST);
   assign w_timeout   = WDOG_EN && (r_cycle_count == WDOG_LAST) && !w_finish;
   assign w_cnt_sat   = &r_cycle_count;

   always_ff @(posedge clock or negedge rst_r) begin
      if (!rst_r) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (abort && (r_state != S_IDLE)) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_next_state = S_LOAD;
            S_LOAD:         if (w_load_end) w_next_state = S_RUN;
            S_RUN:          if (w_finish || w_timeout) w_next_state = S_DONE;
            default:        w_next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge rst_r) begin
      if (!rst_r) begin
         r_start_q     <= 1'b1;
         r_mask        <= '0;
         r_load_cnt    <= '0;
         r_core_run    <= '0;
         r_done_mask   <= '0;
         r_cycle_count <= '0;
         r_timed_out   <= 1'b0;
      end else begin
         r_start_q  <= start_process;
         r_core_run <= (w_next_state == S_RUN) ? r_mask : '0;
         // Abort freezes the run results so they can be inspected afterwards
         if (!abort) begin
            if (w_idle_like && w_start_ok) begin
               r_mask        <= core_mask;
               r_load_cnt    <= '0;
               r_done_mask   <= '0;
               r_cycle_count <= '0;
               r_timed_out   <= 1'b0;
            end
            if (r_state == S_LOAD) begin
               r_load_cnt <= r_load_cnt + 1'b1;
            end
            if (r_state == S_RUN) begin
               r_done_mask <= w_done_next;
               if (!w_cnt_sat) r_cycle_count <= r_cycle_count + 1'b1;
               if (w_timeout) r_timed_out <= 1'b1;
            end
         end
      end
   end

   assign core_run    = r_core_run;
   assign status      = r_state;
   assign g1          = (r_state == S_LOAD);
   assign g2          = (r_state == S_RUN);
   assign g3          = (r_state == S_DONE);
   assign done_mask   = r_done_mask;
   assign cycle_count = r_cycle_count;
   assign timed_out   = r_timed_out;

endmodule
